multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control unit for the MIPS core: the sequential successor to the single-cycle decoder. It runs each instruction through IF/ID/EX/MEM/WB states and issues per-cycle strobes to PC, IR, register file, ALU and memory. Memory accesses can use a req/ready handshake. It also keeps a retired-instruction counter and flags illegal encodings. It sits between the IR register and the shared multi-cycle datapath.

## Interface
- `WAIT_MEM`, default 1: 1 = memory stages wait for `*_ready`; 0 = every memory access completes in one cycle and `*_ready` is ignored.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `inst`  in  32  current IR contents; valid from ID onward.
- `zero`  in  1  ALU zero flag, sampled in EX for `beq`.
- `imem_ready` / `dmem_ready`  in  1  memory completion, sampled in the same cycle as the matching req.
- `imem_req`  out  1  instruction fetch request.
- `dmem_req` / `dmem_we`  out  1  data request and write enable (`we` only with `sw`).
- `ir_write`  out  1  load IR.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load if `zero`.
- `pc_src`  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs.
- `reg_write`  out  1  register-file write strobe.
- `reg_write_src`  out  2  0 = ALU, 1 = MDR, 2 = PC (already +4).
- `reg_dst`  out  2  0 = rt, 1 = rd, 2 = $31.
- `alu_src`  out  1  1 = register rt, 0 = immediate.
- `alu_op`  out  2  0 = add, 1 = sub, 2 = or, 3 = lui.
- `illegal`  out  1  one-cycle pulse on an undecodable instruction.
- `inst_cnt`  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.
- `state`  out  3  current state, for debug.

## Operation
- Supported instructions: addu, subu, ori, lw, sw, beq, lui, jal, jr.
- Field decode:
  - R-type: op == 0; addu funct 0x21, subu 0x23, jr 0x08.
  - ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, lui 0x0F, jal 0x03.
- Strobes are Moore/Mealy combinational from state, decode and ready. All strobes not listed for a state are 0.
- **IF**: `imem_req`=1.
  - On ready: `ir_write`=1, `pc_write`=1 with `pc_src`=0, go to ID.
  - Otherwise stay in IF.
- **ID**:
  - Illegal: pulse `illegal`, go to IF. The instruction is not counted.
  - jal: `reg_write`=1, `reg_dst`=2, `reg_write_src`=2, `pc_write`=1, `pc_src`=2, retire, go to IF.
  - jr: `pc_write`=1, `pc_src`=3, retire, go to IF.
  - All others go to EX.
- **EX**: drive `alu_src`/`alu_op` with the same meanings as the decoder encodings.
  - addu → src 1, op 0. subu → 1, 1. ori → 0, 2. lui → 0, 3. lw/sw → 0, 0.
  - beq → src 1, op 1, `pc_write_cond`=1, `pc_src`=1, retire, go to IF.
  - lw/sw go to MEM; addu/subu/ori/lui go to WB.
- **MEM**: `dmem_req`=1, `dmem_we`=sw.
  - Stay until ready.
  - On ready: sw retires and goes to IF; lw goes to WB.
- **WB**: `reg_write`=1, go to IF, retire.
  - `reg_dst` = 1 for addu/subu, else 0.
  - `reg_write_src` = 1 for lw, else 0.
- Retire means `inst_cnt` += 1 on that clock edge.
- Illegal encodings: any other op; any R-type funct other than the three above.

## Timing
- Reset: state = IF, `inst_cnt` = 0.
  - All strobes are 0 during the reset cycle. `imem_req` is 1 in the first cycle after reset deasserts.
- Reset mid-access drops the request in the same cycle. No retire occurs.
- Latency with zero wait states, in cycles from IF entry to return to IF:
  - jal/jr: 2. beq: 3. addu/subu/ori/lui/sw: 4. lw: 5.
  - Each wait cycle adds 1.
- Handshake: req is held high until ready is seen high. Ready sampled with req low is ignored.
- `WAIT_MEM`=0: IF and MEM each take exactly one cycle regardless of ready.
- `inst_cnt` wraps: at all-ones, one retire gives 0.

## Structure
- `mips_ctrl_pkg` holds:
  - the state enum (IF=0, ID=1, EX=2, MEM=3, WB=4);
  - opcode and funct constants;
  - the `pc_src`, `alu_op`, `reg_dst` and `reg_write_src` encodings.
- Sub-module `mc_decode`: combinational, `inst` → one-hot instruction flags plus `illegal`.
- The top level holds the FSM, the output logic and the counter.

## Test plan
- addu 0x00432021, WAIT_MEM=1, ready tied 1 → states IF,ID,EX,WB.
  - WB has `reg_write`=1, `reg_dst`=1, `alu_op`=0.
  - `inst_cnt` 0→1 after 4 cycles.
- lw 0x8C430004 with `dmem_ready` low for 3 cycles → MEM lasts 4 cycles with `dmem_req` held, `dmem_we`=0.
  - WB has `reg_write_src`=1. Total 8 cycles.
- beq 0x10430002 with `zero`=1, then with `zero`=0.
  - Both: EX has `pc_write_cond`=1, `pc_src`=1, `alu_op`=1.
  - Both return to IF after 3 cycles.
- jal 0x0C000010 then jr 0x03E00008.
  - jal ID: `reg_dst`=2, `reg_write_src`=2, `pc_src`=2.
  - jr ID: `pc_src`=3.
  - Each takes 2 cycles.
- Illegal 0xFC000000 → one `illegal` pulse in ID, back to IF, `inst_cnt` unchanged.
- `rst` asserted in MEM during a sw wait → next cycle state=IF with `dmem_req`=0 and `inst_cnt`=0.
  - Also: CNT_W=4, 16 retires → `inst_cnt` wraps to 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// funct codes, datapath mux selects and the one-hot decode flag bundle.
package mips_ctrl_pkg;

   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EX  = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_JAL   = 6'h03;

   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_JR   = 6'h08;

   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_RS     = 2'd3;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_OR  = 2'd2;
   localparam logic [1:0] ALU_LUI = 2'd3;

   localparam logic [1:0] DST_RT = 2'd0;
   localparam logic [1:0] DST_RD = 2'd1;
   localparam logic [1:0] DST_RA = 2'd2;

   localparam logic [1:0] WSRC_ALU = 2'd0;
   localparam logic [1:0] WSRC_MDR = 2'd1;
   localparam logic [1:0] WSRC_PC  = 2'd2;

   typedef struct packed {
      logic addu;
      logic subu;
      logic jr;
      logic ori;
      logic lw;
      logic sw;
      logic beq;
      logic lui;
      logic jal;
   } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: opcode/funct to one-hot flags plus illegal.
// Zero latency, no flow control.
module mc_decode
   import mips_ctrl_pkg::*;
(
   input  logic [31:0] i_inst,
   output dec_t        o_dec,
   output logic        o_illegal
);

   logic [5:0] w_op;
   logic [5:0] w_fn;
   logic       w_rtype;
   logic       w_unused;

   assign w_op     = i_inst[31:26];
   assign w_fn     = i_inst[5:0];
   assign w_rtype  = (w_op == OP_RTYPE);
   // Register and immediate fields are routed straight to the datapath.
   assign w_unused = ^i_inst[25:6];

   always_comb begin
      o_dec      = '0;
      o_dec.addu = w_rtype && (w_fn == FN_ADDU);
      o_dec.subu = w_rtype && (w_fn == FN_SUBU);
      o_dec.jr   = w_rtype && (w_fn == FN_JR);
      o_dec.ori  = (w_op == OP_ORI);
      o_dec.lw   = (w_op == OP_LW);
      o_dec.sw   = (w_op == OP_SW);
      o_dec.beq  = (w_op == OP_BEQ);
      o_dec.lui  = (w_op == OP_LUI);
      o_dec.jal  = (w_op == OP_JAL);
   end

   assign o_illegal = ~|o_dec;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with retire counter.
// 2-5 cycles per instruction; IF/MEM hold req until ready when WAIT_MEM=1.
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int WAIT_MEM = 1,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst,
   input  logic             zero,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic [1:0]       pc_src,
   output logic             reg_write,
   output logic [1:0]       reg_write_src,
   output logic [1:0]       reg_dst,
   output logic             alu_src,
   output logic [1:0]       alu_op,
   output logic             illegal,
   output logic [CNT_W-1:0] inst_cnt,
   output logic [2:0]       state
);

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_inst_cnt;
   logic [2:0]       w_next;
   logic             w_retire;
   logic             w_imem_done;
   logic             w_dmem_done;
   dec_t             w_dec;
   logic             w_illegal;

   mc_decode u_decode (
      .i_inst    (inst),
      .o_dec     (w_dec),
      .o_illegal (w_illegal)
   );

   assign w_imem_done = (WAIT_MEM == 0) ? 1'b1 : imem_ready;
   assign w_dmem_done = (WAIT_MEM == 0) ? 1'b1 : dmem_ready;

   // Strobes are forced low while rst is high so an in-flight request drops immediately.
   always_comb begin
      w_next        = r_state;
      w_retire      = 1'b0;
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = PC_PLUS4;
      reg_write     = 1'b0;
      reg_write_src = WSRC_ALU;
      reg_dst       = DST_RT;
      alu_src       = 1'b0;
      alu_op        = ALU_ADD;
      illegal       = 1'b0;
      if (!rst) begin
         case (r_state)
            S_IF: begin
               imem_req = 1'b1;
               if (w_imem_done) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  w_next   = S_ID;
               end
            end
            S_ID: begin
               w_next = S_EX;
               if (w_illegal) begin
                  illegal = 1'b1;
                  w_next  = S_IF;
               end else if (w_dec.jal) begin
                  reg_write     = 1'b1;
                  reg_dst       = DST_RA;
                  reg_write_src = WSRC_PC;
                  pc_write      = 1'b1;
                  pc_src        = PC_JUMP;
                  w_retire      = 1'b1;
                  w_next        = S_IF;
               end else if (w_dec.jr) begin
                  pc_write = 1'b1;
                  pc_src   = PC_RS;
                  w_retire = 1'b1;
                  w_next   = S_IF;
               end
            end
            S_EX: begin
               alu_src = w_dec.addu | w_dec.subu | w_dec.beq;
               if (w_dec.subu || w_dec.beq) alu_op = ALU_SUB;
               else if (w_dec.ori)          alu_op = ALU_OR;
               else if (w_dec.lui)          alu_op = ALU_LUI;
               if (w_dec.beq) begin
                  pc_write_cond = 1'b1;
                  pc_src        = PC_BRANCH;
                  w_retire      = 1'b1;
                  w_next        = S_IF;
               end else if (w_dec.lw || w_dec.sw) begin
                  w_next = S_MEM;
               end else begin
                  w_next = S_WB;
               end
            end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = w_dec.sw;
               if (w_dmem_done) begin
                  if (w_dec.sw) begin
                     w_retire = 1'b1;
                     w_next   = S_IF;
                  end else begin
                     w_next = S_WB;
                  end
               end
            end
            S_WB: begin
               reg_write     = 1'b1;
               reg_dst       = (w_dec.addu || w_dec.subu) ? DST_RD : DST_RT;
               reg_write_src = w_dec.lw ? WSRC_MDR : WSRC_ALU;
               w_retire      = 1'b1;
               w_next        = S_IF;
            end
            default: w_next = S_IF;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IF;
         r_inst_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) r_inst_cnt <= r_inst_cnt + CNT_W'(1);
      end
   end

   assign state    = r_state;
   assign inst_cnt = r_inst_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-state strobes, handshake waits,
// reset mid-access, and counter wrap on a CNT_W=4, WAIT_MEM=0 instance.
module tb_multicycle_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] inst;
   logic        zero;
   logic        imem_ready;
   logic        dmem_ready;
   logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_write_cond;
   logic [1:0]  pc_src, reg_write_src, reg_dst, alu_op;
   logic        reg_write, alu_src, illegal;
   logic [31:0] inst_cnt;
   logic [2:0]  state;

   logic        rdy4;
   logic [3:0]  cnt4;
   logic [2:0]  st4;
   logic        unused4_imem_req, unused4_dmem_req, unused4_dmem_we, unused4_ir_write;
   logic        unused4_pc_write, unused4_pc_write_cond, unused4_reg_write, unused4_alu_src;
   logic        unused4_illegal;
   logic [1:0]  unused4_pc_src, unused4_reg_write_src, unused4_reg_dst, unused4_alu_op;

   int n_tot = 0;
   int n_bad = 0;

   multicycle_ctrl #(.WAIT_MEM(1), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .inst(inst), .zero(zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .pc_src(pc_src), .reg_write(reg_write), .reg_write_src(reg_write_src),
      .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op),
      .illegal(illegal), .inst_cnt(inst_cnt), .state(state)
   );

   multicycle_ctrl #(.WAIT_MEM(0), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .inst(inst), .zero(zero),
      .imem_ready(rdy4), .dmem_ready(rdy4),
      .imem_req(unused4_imem_req), .dmem_req(unused4_dmem_req), .dmem_we(unused4_dmem_we),
      .ir_write(unused4_ir_write), .pc_write(unused4_pc_write),
      .pc_write_cond(unused4_pc_write_cond), .pc_src(unused4_pc_src),
      .reg_write(unused4_reg_write), .reg_write_src(unused4_reg_write_src),
      .reg_dst(unused4_reg_dst), .alu_src(unused4_alu_src), .alu_op(unused4_alu_op),
      .illegal(unused4_illegal), .inst_cnt(cnt4), .state(st4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; inst = 32'h0; zero = 1'b0;
      imem_ready = 1'b1; dmem_ready = 1'b1; rdy4 = 1'b0;
      tick(); tick();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_cnt", inst_cnt, 32'd0);
      chk("rst_ireq", 32'(imem_req), 32'd0);
      chk("rst_cnt4", 32'(cnt4), 32'd0);

      // addu: IF, ID, EX, WB
      rst = 1'b0; inst = 32'h00432021; #1;
      chk("if_ireq", 32'(imem_req), 32'd1);
      chk("if_irw", 32'(ir_write), 32'd1);
      chk("if_pcw", 32'(pc_write), 32'd1);
      chk("if_pcsrc", 32'(pc_src), 32'd0);
      tick();
      chk("addu_id", 32'(state), 32'd1);
      chk("addu_id_rw", 32'(reg_write), 32'd0);
      tick();
      chk("addu_ex", 32'(state), 32'd2);
      chk("addu_ex_src", 32'(alu_src), 32'd1);
      chk("addu_ex_op", 32'(alu_op), 32'd0);
      tick();
      chk("addu_wb", 32'(state), 32'd4);
      chk("addu_wb_rw", 32'(reg_write), 32'd1);
      chk("addu_wb_dst", 32'(reg_dst), 32'd1);
      chk("addu_wb_op", 32'(alu_op), 32'd0);
      chk("addu_wb_cnt", inst_cnt, 32'd0);
      tick();
      chk("addu_done", 32'(state), 32'd0);
      chk("addu_cnt", inst_cnt, 32'd1);

      // lw with three dmem wait cycles
      inst = 32'h8C430004; dmem_ready = 1'b0;
      tick();
      chk("lw_id", 32'(state), 32'd1);
      tick();
      chk("lw_ex_src", 32'(alu_src), 32'd0);
      chk("lw_ex_op", 32'(alu_op), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("lw_mem%0d", i), 32'(state), 32'd3);
         chk($sformatf("lw_req%0d", i), 32'(dmem_req), 32'd1);
         chk($sformatf("lw_we%0d", i), 32'(dmem_we), 32'd0);
      end
      tick();
      dmem_ready = 1'b1; #1;
      chk("lw_mem3", 32'(state), 32'd3);
      chk("lw_req3", 32'(dmem_req), 32'd1);
      tick();
      chk("lw_wb", 32'(state), 32'd4);
      chk("lw_wb_rw", 32'(reg_write), 32'd1);
      chk("lw_wb_wsrc", 32'(reg_write_src), 32'd1);
      chk("lw_wb_dst", 32'(reg_dst), 32'd0);
      tick();
      chk("lw_done", 32'(state), 32'd0);
      chk("lw_cnt", inst_cnt, 32'd2);

      // beq, zero=1 with one imem wait, then zero=0
      inst = 32'h10430002; zero = 1'b1; imem_ready = 1'b0; #1;
      chk("if_wait_irw", 32'(ir_write), 32'd0);
      chk("if_wait_ireq", 32'(imem_req), 32'd1);
      tick();
      chk("if_wait_state", 32'(state), 32'd0);
      imem_ready = 1'b1;
      for (int z = 0; z < 2; z++) begin
         tick();
         chk($sformatf("beq%0d_id", z), 32'(state), 32'd1);
         tick();
         chk($sformatf("beq%0d_ex", z), 32'(state), 32'd2);
         chk($sformatf("beq%0d_pwc", z), 32'(pc_write_cond), 32'd1);
         chk($sformatf("beq%0d_pcsrc", z), 32'(pc_src), 32'd1);
         chk($sformatf("beq%0d_op", z), 32'(alu_op), 32'd1);
         tick();
         chk($sformatf("beq%0d_done", z), 32'(state), 32'd0);
         chk($sformatf("beq%0d_cnt", z), inst_cnt, 32'(3 + z));
         zero = 1'b0;
      end

      // jal then jr
      inst = 32'h0C000010;
      tick();
      chk("jal_id", 32'(state), 32'd1);
      chk("jal_rw", 32'(reg_write), 32'd1);
      chk("jal_dst", 32'(reg_dst), 32'd2);
      chk("jal_wsrc", 32'(reg_write_src), 32'd2);
      chk("jal_pcsrc", 32'(pc_src), 32'd2);
      chk("jal_pcw", 32'(pc_write), 32'd1);
      tick();
      chk("jal_done", 32'(state), 32'd0);
      chk("jal_cnt", inst_cnt, 32'd5);
      inst = 32'h03E00008;
      tick();
      chk("jr_pcsrc", 32'(pc_src), 32'd3);
      chk("jr_pcw", 32'(pc_write), 32'd1);
      chk("jr_rw", 32'(reg_write), 32'd0);
      tick();
      chk("jr_done", 32'(state), 32'd0);
      chk("jr_cnt", inst_cnt, 32'd6);

      // illegal encoding
      inst = 32'hFC000000;
      tick();
      chk("ill_pulse", 32'(illegal), 32'd1);
      tick();
      chk("ill_state", 32'(state), 32'd0);
      chk("ill_low", 32'(illegal), 32'd0);
      chk("ill_cnt", inst_cnt, 32'd6);

      // sw, reset during the MEM wait
      inst = 32'hAC430004; dmem_ready = 1'b0;
      tick(); tick(); tick();
      chk("sw_mem", 32'(state), 32'd3);
      chk("sw_req", 32'(dmem_req), 32'd1);
      chk("sw_we", 32'(dmem_we), 32'd1);
      tick();
      chk("sw_hold", 32'(state), 32'd3);
      rst = 1'b1; #1;
      chk("sw_rst_drop", 32'(dmem_req), 32'd0);
      tick();
      chk("sw_rst_state", 32'(state), 32'd0);
      chk("sw_rst_req", 32'(dmem_req), 32'd0);
      chk("sw_rst_cnt", inst_cnt, 32'd0);

      // 16 addu retires on the 4-bit counter, ready held low (WAIT_MEM=0)
      rst = 1'b0; inst = 32'h00432021; #1;
      tick();
      chk("w0_if_noready", 32'(st4), 32'd1);
      repeat (59) tick();
      chk("wrap_cnt15", 32'(cnt4), 32'd15);
      chk("wide_cnt15", inst_cnt, 32'd15);
      repeat (4) tick();
      chk("wrap_cnt0", 32'(cnt4), 32'd0);
      chk("wrap_state", 32'(st4), 32'd0);
      chk("wide_cnt16", inst_cnt, 32'd16);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
